// File: rtl/branch_predictor.sv
// Bimodal branch predictor with branch target buffer, beside fetch.
// Optional BP_STATS_EN adds lookup/update/mispredict event counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] PCF,
  output logic            predTakenF,
  output logic [PC_W-1:0] predTargetF,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  input  logic            clear,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = PC_W - IW - 2;

  localparam logic [CTR_W-1:0] C_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] C_WNT = C_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] C_MAX = '1;
  localparam logic [CTR_W-1:0] C_MIN = '0;

  logic [ENTRIES-1:0] vld_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IW-1:0]    f_idx;
  logic [TW-1:0]    f_tag;
  logic             f_hit;
  logic [IW-1:0]    u_idx;
  logic [TW-1:0]    u_tag;
  logic             u_hit;
  logic [CTR_W-1:0] u_ctr;
  logic [CTR_W-1:0] ctr_inc;
  logic [CTR_W-1:0] ctr_dec;
  logic             misp_cond;

  // PCs are word aligned, so the two low bits never select anything
  logic unused_lsb;
  assign unused_lsb = ^{PCF[1:0], upd_pc[1:0]};

  assign f_idx = PCF[IW+1:2];
  assign f_tag = PCF[PC_W-1:IW+2];
  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[PC_W-1:IW+2];

  // Fetch-side lookup straight from registered state, no update bypass
  always_comb begin
    f_hit       = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    predTakenF  = lookup_valid && f_hit && ctr_q[f_idx][CTR_W-1];
    predTargetF = predTakenF ? tgt_q[f_idx] : '0;
  end

  // Training-side hit check and saturating counter neighbours
  always_comb begin
    u_hit   = vld_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr   = ctr_q[u_idx];
    ctr_inc = (u_ctr == C_MAX) ? u_ctr : u_ctr + CTR_W'(1);
    ctr_dec = (u_ctr == C_MIN) ? u_ctr : u_ctr - CTR_W'(1);
    misp_cond = (upd_pred_taken != upd_taken) ||
                (upd_taken && (upd_pred_target != upd_target));
  end

  // Entry array: reset, then clear, then training write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= C_WNT;
      end
    end else if (clear) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= C_WNT;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr_q[u_idx] <= ctr_inc;
          tgt_q[u_idx] <= upd_target;
        end else begin
          ctr_q[u_idx] <= ctr_dec;
        end
      end else if (upd_taken) begin
        vld_q[u_idx] <= 1'b1;
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= upd_target;
        ctr_q[u_idx] <= C_WT;
      end
    end
  end

  // One-cycle mispredict pulse, independent of clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= upd_valid && misp_cond;
    end
  end

`ifdef BP_STATS_EN
  // Free-running event counters, untouched by clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_valid) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (upd_valid) begin
        stat_updates <= stat_updates + 32'd1;
      end
      if (upd_valid && misp_cond) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a behavioural model.
// Directed cases pin the model with hand-computed expectations.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int LOG2E   = 4;
  localparam int PC_W    = 32;
  localparam int CTR_W   = 2;
  localparam int HALF    = 1 << (CTR_W - 1);
  localparam int CMAX    = (1 << CTR_W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            lookup_valid = 1'b0;
  logic [PC_W-1:0] PCF = '0;
  logic            predTakenF;
  logic [PC_W-1:0] predTargetF;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [PC_W-1:0] upd_target = '0;
  logic            upd_pred_taken = 1'b0;
  logic [PC_W-1:0] upd_pred_target = '0;
  logic            clear = 1'b0;
  logic            mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(
    .ENTRIES(ENTRIES),
    .PC_W(PC_W),
    .CTR_W(CTR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lookup_valid(lookup_valid),
    .PCF(PCF),
    .predTakenF(predTakenF),
    .predTargetF(predTargetF),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .clear(clear),
    .mispredict(mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers
  bit          mv   [ENTRIES];
  logic [31:0] mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mctr [ENTRIES];
  bit          exp_misp;
  int unsigned s_look;
  int unsigned s_upd;
  int unsigned s_misp;
  bit          cmp_en = 1'b0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (2 + LOG2E);
  endfunction

  // Model state advance on each edge or on asynchronous reset
  always @(posedge clk or posedge reset) begin
    int  i;
    bit  hit;
    bit  mc;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        mv[k] = 1'b0;
        mtag[k] = '0;
        mtgt[k] = '0;
        mctr[k] = HALF - 1;
      end
      exp_misp = 1'b0;
      s_look = 0;
      s_upd = 0;
      s_misp = 0;
    end else begin
      mc = upd_valid && ((upd_pred_taken != upd_taken) ||
           (upd_taken && upd_pred_target != upd_target));
      exp_misp = mc;
      if (lookup_valid) s_look++;
      if (upd_valid) s_upd++;
      if (mc) s_misp++;
      i = idx_of(upd_pc);
      hit = mv[i] && (mtag[i] == tag_of(upd_pc));
      if (clear) begin
        for (int k = 0; k < ENTRIES; k++) begin
          mv[k] = 1'b0;
          mctr[k] = HALF - 1;
        end
      end else if (upd_valid) begin
        if (hit && upd_taken) begin
          mctr[i] = (mctr[i] + 1 > CMAX) ? CMAX : mctr[i] + 1;
          mtgt[i] = upd_target;
        end else if (hit) begin
          mctr[i] = (mctr[i] - 1 < 0) ? 0 : mctr[i] - 1;
        end else if (upd_taken) begin
          mv[i] = 1'b1;
          mtag[i] = tag_of(upd_pc);
          mtgt[i] = upd_target;
          mctr[i] = HALF;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int  i;
    bit  t;
    if (cmp_en) begin
      i = idx_of(PCF);
      t = lookup_valid && mv[i] && (mtag[i] == tag_of(PCF)) &&
          (mctr[i] >= HALF);
      check("model_taken", {31'd0, predTakenF}, {31'd0, t});
      check("model_target", predTargetF, t ? mtgt[i] : 32'd0);
      check("model_misp", {31'd0, mispredict}, {31'd0, exp_misp});
`ifdef BP_STATS_EN
      check("model_stat_look", stat_lookups, s_look);
      check("model_stat_upd", stat_updates, s_upd);
      check("model_stat_misp", stat_mispredicts, s_misp);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic look(logic [31:0] pc);
    lookup_valid = 1'b1;
    PCF = pc;
  endtask

  task automatic upd(logic [31:0] pc, logic tk, logic [31:0] tg,
                     logic ptk, logic [31:0] ptg);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tg;
    upd_pred_taken = ptk;
    upd_pred_target = ptg;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
        $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // reset state
    idle(); look(32'h40);
    #1;
    check("rst_taken", {31'd0, predTakenF}, 32'd0);
    check("rst_target", predTargetF, 32'd0);
    tick();
    check("rst_misp", {31'd0, mispredict}, 32'd0);

    // allocate and hit
    idle(); upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    check("alloc_misp", {31'd0, mispredict}, 32'd1);
    idle(); look(32'h40);
    #1;
    check("alloc_taken", {31'd0, predTakenF}, 32'd1);
    check("alloc_target", predTargetF, 32'h100);
    tick();
    check("misp_pulse_end", {31'd0, mispredict}, 32'd0);

    // same-cycle lookup sees old state; hysteresis
    idle(); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); look(32'h40);
    #1;
    check("same_cyc_old", {31'd0, predTakenF}, 32'd1);
    tick();
    check("nt_misp", {31'd0, mispredict}, 32'd1);
    idle(); look(32'h40);
    #1;
    check("hyst_nt", {31'd0, predTakenF}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(); upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick();
    end
    check("correct_no_misp", {31'd0, mispredict}, 32'd0);
    idle(); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    idle(); look(32'h40);
    #1;
    check("hyst_sat_taken", {31'd0, predTakenF}, 32'd1);
    check("hyst_sat_target", predTargetF, 32'h100);
    tick();

    // alias eviction
    idle(); upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    idle(); look(32'h40);
    #1;
    check("alias_evict", {31'd0, predTakenF}, 32'd0);
    tick();
    look(32'h80);
    #1;
    check("alias_new_taken", {31'd0, predTakenF}, 32'd1);
    check("alias_new_target", predTargetF, 32'h200);
    tick();

    // clear with a simultaneous update
    idle(); clear = 1'b1; upd(32'hC0, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    idle();
    check("clr_misp", {31'd0, mispredict}, 32'd1);
    look(32'hC0);
    #1;
    check("clr_no_alloc", {31'd0, predTakenF}, 32'd0);
    tick();
    look(32'h80);
    #1;
    check("clr_flush", {31'd0, predTakenF}, 32'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tg;
      idle();
      lookup_valid = ($urandom_range(0, 3) != 0);
      PCF = rand_pc();
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_pc = rand_pc();
      upd_taken = ($urandom_range(0, 4) < 3);
      tg = {$urandom_range(0, 7), 2'b00};
      upd_target = tg;
      upd_pred_taken = $urandom_range(0, 1);
      upd_pred_target = ($urandom_range(0, 1) != 0) ? tg : $urandom;
      clear = ($urandom_range(0, 49) == 0);
      tick();
    end

    // asynchronous reset between edges
    idle(); upd(32'h40, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    idle(); look(32'h40);
    #1;
    check("pre_rst_taken", {31'd0, predTakenF}, 32'd1);
    check("pre_rst_misp", {31'd0, mispredict}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_taken", {31'd0, predTakenF}, 32'd0);
    check("async_rst_target", predTargetF, 32'd0);
    check("async_rst_misp", {31'd0, mispredict}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_taken", {31'd0, predTakenF}, 32'd0);
    tick();

`ifdef BP_STATS_EN
    // 5 lookups, 3 updates, 2 mispredicts since the reset above
    idle(); look(32'h10); tick();
    idle(); look(32'h14); upd(32'h10, 1'b1, 32'h80, 1'b0, 32'h0); tick();
    idle(); look(32'h18); upd(32'h14, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    idle(); look(32'h1C); upd(32'h18, 1'b0, 32'h0, 1'b1, 32'h0); tick();
    idle(); tick();
    check("stat_lookups", stat_lookups, 32'd5);
    check("stat_updates", stat_updates, 32'd3);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
